if_stage_sramlike: RTL and testbench
====================================

// Module: if_stage_sramlike
// PURPOSE
//  Parametrised instruction-fetch stage for the SRAM-like (req/addr_ok/data_ok) instruction bus.
//  Supports multiple outstanding requests and an IBUF_DEPTH-entry in-order instruction buffer.
//  Squashes stale responses on redirect (exception > ertn > branch) and raises ADEF without a bus access.
//  Sits between the PC/redirect sources and the decode stage; drives the standard 65-bit fs2ds_bus.
// PARAMETERS
//  RESET_PC    32'h1c000000  address of first fetch after reset
//  IBUF_DEPTH  4             instruction buffer entries; power of two, >=2; also caps outstanding requests
//  NOP_INST    32'h03400000  instruction word substituted on ADEF entries
// PORTS
//  clk          in   1   clock
//  resetn       in   1   asynchronous, active-low reset
//  inst_req     out  1   fetch request valid
//  inst_addr    out  32  fetch address (= fetch_pc)
//  inst_addr_ok in   1   request accepted this cycle when inst_req=1
//  inst_data_ok in   1   in-order read data valid
//  inst_rdata   in   32  read data
//  fs2ds_valid  out  1   buffer head valid toward decode
//  fs2ds_bus    out  65  {adef, pc[31:0], inst[31:0]} of buffer head
//  ds_allowin   in   1   decode accepts head this cycle
//  br_taken     in   1   branch redirect
//  br_target    in   32  branch target
//  ws_ex        in   1   exception flush from writeback
//  ex_entry     in   32  exception entry
//  ertn_flush   in   1   ertn flush from writeback
//  ertn_entry   in   32  ertn return address
// BEHAVIOUR
//  - Reset (async, resetn=0):
//    - fetch_pc=RESET_PC; buffer empty; inflight=0; discard=0; halted=0.
//    - inst_req=0; fs2ds_valid=0.
//  - Redirect: redir = ws_ex|ertn_flush|br_taken. Target priority is ex_entry > ertn_entry > br_target.
//  - Request: inst_req = ~halted & ~redir & ~fetch_pc[1:0]!=0 & (inflight+count < IBUF_DEPTH).
//  - Accept (inst_req & inst_addr_ok):
//    - fetch_pc += 4 (wraps modulo 2^32).
//    - Push fetch_pc into the inflight-PC FIFO; inflight++.
//  - Response (inst_data_ok):
//    - Pop the inflight-PC FIFO; inflight--.
//    - If discard>0: drop the data, discard--.
//    - Else: write {0,pc,inst_rdata} at buffer tail. Visible on fs2ds_bus the next cycle.
//  - data_ok with inflight==0 is a protocol violation; ignore it and change no state.
//  - Output:
//    - fs2ds_valid = ~empty & ~redir (combinational).
//    - fs2ds_bus = buffer head.
//    - Pop the head when fs2ds_valid & ds_allowin.
//  - Redirect in cycle t, all effects at edge t+1:
//    - fetch_pc = target; buffer cleared; halted cleared.
//    - discard = discard + inflight after this cycle's accept/response updates, counting only non-discarded responses.
//    - Inflight-PC FIFO is kept, so PCs stay aligned with dropped data.
//    - Redirect wins over a same-cycle pop, accept or write.
//  - Misaligned fetch_pc (fetch_pc[1:0]!=0), no redirect:
//    - Issue no bus request.
//    - Once inflight==0 and a slot is free, write {1,fetch_pc,NOP_INST} and set halted=1.
//    - Stay halted until the next redirect.
//  - Occupancy invariant: inflight + count <= IBUF_DEPTH. Buffer can never overflow, so no write is lost.
//  - Counters: inflight and count are $clog2(IBUF_DEPTH+1) bits; buffer pointers are $clog2(IBUF_DEPTH) bits and wrap.
//  - Latency (addr_ok and data_ok immediate):
//    - Redirect at t -> req at t+1 -> data_ok at t+2 -> fs2ds_valid at t+3.
//    - Steady-state throughput: 1 instruction/cycle.
// TESTING
//  T1 Reset release, addr_ok=1, data_ok 1 cycle after accept, ds_allowin=1 -> inst_addr 1c000000,04,08..; fs2ds pcs in order, inst=rdata, adef=0.
//  T2 ds_allowin=0 for 12 cycles, DEPTH=4 -> inst_req drops once inflight+count=4; on release, 4 entries drain in pc order with no loss or duplicates.
//  T3 br_taken target 1c000100 with 2 inflight -> both responses dropped; next fs2ds pc=1c000100; no stale pc ever valid.
//  T4 ws_ex, ertn_flush and br_taken in the same cycle as addr_ok -> fetch_pc=ex_entry; accepted request discarded; buffer empty next cycle.
//  T5 ertn_entry=1c000102 -> no inst_req; one entry {1,1c000102,03400000}; inst_req stays 0 until ws_ex redirect to 1c008000 resumes fetch.
//  T6 resetn asserted mid-stream with 3 inflight -> inst_req and fs2ds_valid 0 immediately; after release, fetch restarts at RESET_PC and late data_ok is ignored.

Source files
------------

// File: rtl/if_stage_sramlike.sv
// Instruction-fetch stage for an SRAM-like (req/addr_ok/data_ok) instruction bus.
// Keeps multiple requests outstanding, buffers responses in order and squashes stale data on redirect.
module if_stage_sramlike #(
   parameter logic [31:0] RESET_PC   = 32'h1c000000,
   parameter int unsigned IBUF_DEPTH = 4,
   parameter logic [31:0] NOP_INST   = 32'h03400000
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        fs2ds_valid,
   output logic [64:0] fs2ds_bus,
   input  logic        ds_allowin,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        ws_ex,
   input  logic [31:0] ex_entry,
   input  logic        ertn_flush,
   input  logic [31:0] ertn_entry
);

   localparam int unsigned CW = $clog2(IBUF_DEPTH + 1);
   localparam int unsigned PW = $clog2(IBUF_DEPTH);
   localparam logic [CW-1:0] CntMax = CW'(IBUF_DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          halted_q, halted_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [PW-1:0] ifq_head_q, ifq_head_d, ifq_tail_q, ifq_tail_d;

   logic [31:0] buf_pc_q   [IBUF_DEPTH];
   logic [31:0] buf_inst_q [IBUF_DEPTH];
   logic        buf_adef_q [IBUF_DEPTH];
   logic [31:0] ifq_pc_q   [IBUF_DEPTH];

   logic          redir;
   logic [31:0]   redir_target;
   logic          misaligned;
   logic          has_room;
   logic          accept;
   logic          resp;
   logic          resp_keep;
   logic          adef_wr;
   logic          buf_wr;
   logic          pop;
   logic [31:0]   wr_pc;
   logic [31:0]   wr_inst;
   logic [CW-1:0] inflight_nxt;
   logic [CW-1:0] discard_dec;

   always_comb begin
      redir = ws_ex | ertn_flush | br_taken;
      if (ws_ex) begin
         redir_target = ex_entry;
      end else if (ertn_flush) begin
         redir_target = ertn_entry;
      end else begin
         redir_target = br_target;
      end
   end

   // Outstanding requests reserve a buffer slot, so a response always has room.
   assign misaligned = fetch_pc_q[1:0] != 2'b00;
   assign has_room   = ({1'b0, inflight_q} + {1'b0, count_q}) < {1'b0, CntMax};

   // Gated by resetn so the request drops the moment reset is asserted.
   assign inst_req  = resetn & ~halted_q & ~redir & ~misaligned & has_room;
   assign inst_addr = fetch_pc_q;
   assign accept    = inst_req & inst_addr_ok;

   // A data_ok with nothing outstanding is a protocol violation and is ignored.
   assign resp      = inst_data_ok & (inflight_q != '0);
   assign resp_keep = resp & (discard_q == '0);
   assign adef_wr   = ~halted_q & ~redir & misaligned & (inflight_q == '0) & (count_q < CntMax);
   assign buf_wr    = ~redir & (resp_keep | adef_wr);

   assign fs2ds_valid = (count_q != '0) & ~redir;
   assign fs2ds_bus   = {buf_adef_q[head_q], buf_pc_q[head_q], buf_inst_q[head_q]};
   assign pop         = fs2ds_valid & ds_allowin;

   assign wr_pc   = adef_wr ? fetch_pc_q : ifq_pc_q[ifq_head_q];
   assign wr_inst = adef_wr ? NOP_INST : inst_rdata;

   assign inflight_nxt = inflight_q + CW'(accept) - CW'(resp);
   assign discard_dec  = discard_q - CW'(resp & (discard_q != '0));

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      halted_d   = halted_q;
      discard_d  = discard_dec;
      inflight_d = inflight_nxt;
      ifq_head_d = ifq_head_q + PW'(resp);
      ifq_tail_d = ifq_tail_q + PW'(accept);
      head_d     = head_q + PW'(pop);
      tail_d     = tail_q + PW'(buf_wr);
      count_d    = count_q + CW'(buf_wr) - CW'(pop);

      if (redir) begin
         fetch_pc_d = redir_target;
         halted_d   = 1'b0;
         // Everything still outstanding after this cycle belongs to the old path.
         discard_d  = inflight_nxt;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (adef_wr) begin
            halted_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fetch_pc_q <= RESET_PC;
         halted_q   <= 1'b0;
         discard_q  <= '0;
         inflight_q <= '0;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         ifq_head_q <= '0;
         ifq_tail_q <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         halted_q   <= halted_d;
         discard_q  <= discard_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         ifq_head_q <= ifq_head_d;
         ifq_tail_q <= ifq_tail_d;
      end
   end

   // Storage arrays need no reset; occupancy is tracked by the counters above.
   always_ff @(posedge clk) begin
      if (buf_wr) begin
         buf_pc_q[tail_q]   <= wr_pc;
         buf_inst_q[tail_q] <= wr_inst;
         buf_adef_q[tail_q] <= adef_wr;
      end
      if (accept) begin
         ifq_pc_q[ifq_tail_q] <= fetch_pc_q;
      end
   end

endmodule

// File: tb/tb_if_stage_sramlike.sv
// Directed bench for if_stage_sramlike: bus responder answers one cycle after accept,
// every delivered entry and request address is logged and compared against hand-derived values.
module tb_if_stage_sramlike;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        fs2ds_valid;
   logic [64:0] fs2ds_bus;
   logic        ds_allowin;
   logic        br_taken;
   logic [31:0] br_target;
   logic        ws_ex;
   logic [31:0] ex_entry;
   logic        ertn_flush;
   logic [31:0] ertn_entry;

   always #5 clk = ~clk;

   if_stage_sramlike dut (
      .clk          (clk),
      .resetn       (resetn),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .fs2ds_valid  (fs2ds_valid),
      .fs2ds_bus    (fs2ds_bus),
      .ds_allowin   (ds_allowin),
      .br_taken     (br_taken),
      .br_target    (br_target),
      .ws_ex        (ws_ex),
      .ex_entry     (ex_entry),
      .ertn_flush   (ertn_flush),
      .ertn_entry   (ertn_entry)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic        resp_en;
   logic [31:0] pend[$];
   logic [31:0] req_log[$];
   logic [64:0] got[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5a5a5a5a;
   endfunction

   function automatic logic [64:0] ent(input logic adef, input logic [31:0] pc,
                                       input logic [31:0] inst);
      return {adef, pc, inst};
   endfunction

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One cycle, starting and ending on a falling edge.
   task automatic tick();
      logic acc, rsp, pp;
      if (resp_en && pend.size() > 0) begin
         inst_data_ok = 1'b1;
         inst_rdata   = mem_word(pend[0]);
      end else begin
         inst_data_ok = 1'b0;
         inst_rdata   = 32'h0;
      end
      #1;
      acc = inst_req & inst_addr_ok;
      rsp = inst_data_ok;
      pp  = fs2ds_valid & ds_allowin;
      if (acc) begin
         pend.push_back(inst_addr);
         req_log.push_back(inst_addr);
      end
      if (rsp) void'(pend.pop_front());
      if (pp) got.push_back(fs2ds_bus);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      resetn       = 1'b0;
      inst_addr_ok = 1'b1;
      inst_data_ok = 1'b0;
      inst_rdata   = 32'h0;
      ds_allowin   = 1'b1;
      br_taken     = 1'b0;
      br_target    = 32'h0;
      ws_ex        = 1'b0;
      ex_entry     = 32'h0;
      ertn_flush   = 1'b0;
      ertn_entry   = 32'h0;
      resp_en      = 1'b1;
      #1;
      chk("reset_req", 65'(inst_req), 65'(1'b0));
      chk("reset_valid", 65'(fs2ds_valid), 65'(1'b0));

      // T1: streaming fetch
      @(negedge clk);
      resetn = 1'b1;
      #1;
      chk("t1_first_addr", 65'(inst_addr), 65'(32'h1c000000));
      repeat (8) tick();
      chk("t1_req0", 65'(req_log[0]), 65'(32'h1c000000));
      chk("t1_req1", 65'(req_log[1]), 65'(32'h1c000004));
      chk("t1_req2", 65'(req_log[2]), 65'(32'h1c000008));
      chk("t1_cnt", 65'(got.size()), 65'(6));
      chk("t1_e0", got[0], ent(1'b0, 32'h1c000000, mem_word(32'h1c000000)));
      chk("t1_e1", got[1], ent(1'b0, 32'h1c000004, mem_word(32'h1c000004)));
      chk("t1_e2", got[2], ent(1'b0, 32'h1c000008, mem_word(32'h1c000008)));
      chk("t1_e5", got[5], ent(1'b0, 32'h1c000014, mem_word(32'h1c000014)));

      // T2: decode stall fills buffer, then drains
      ds_allowin = 1'b0;
      repeat (12) tick();
      chk("t2_stall_cnt", 65'(got.size()), 65'(6));
      chk("t2_req_off", 65'(inst_req), 65'(1'b0));
      chk("t2_valid", 65'(fs2ds_valid), 65'(1'b1));
      chk("t2_head", fs2ds_bus, ent(1'b0, 32'h1c000018, mem_word(32'h1c000018)));
      chk("t2_reqs", 65'(req_log.size()), 65'(10));
      ds_allowin = 1'b1;
      repeat (4) tick();
      chk("t2_d0", got[6], ent(1'b0, 32'h1c000018, mem_word(32'h1c000018)));
      chk("t2_d1", got[7], ent(1'b0, 32'h1c00001c, mem_word(32'h1c00001c)));
      chk("t2_d2", got[8], ent(1'b0, 32'h1c000020, mem_word(32'h1c000020)));
      chk("t2_d3", got[9], ent(1'b0, 32'h1c000024, mem_word(32'h1c000024)));

      // T3: branch with two requests outstanding
      resp_en = 1'b0;
      tick();
      br_taken  = 1'b1;
      br_target = 32'h1c000100;
      #1;
      chk("t3_req_redir", 65'(inst_req), 65'(1'b0));
      chk("t3_valid_redir", 65'(fs2ds_valid), 65'(1'b0));
      tick();
      br_taken = 1'b0;
      resp_en  = 1'b1;
      repeat (4) tick();
      chk("t3_cnt", 65'(got.size()), 65'(12));
      chk("t3_pre", got[10], ent(1'b0, 32'h1c000028, mem_word(32'h1c000028)));
      chk("t3_tgt", got[11], ent(1'b0, 32'h1c000100, mem_word(32'h1c000100)));
      chk("t3_req_tgt", 65'(req_log[14]), 65'(32'h1c000100));

      // T4: all three redirect sources at once
      ws_ex      = 1'b1;
      ex_entry   = 32'h1c004000;
      ertn_flush = 1'b1;
      ertn_entry = 32'h1c005000;
      br_taken   = 1'b1;
      br_target  = 32'h1c006000;
      tick();
      ws_ex      = 1'b0;
      ertn_flush = 1'b0;
      br_taken   = 1'b0;
      #1;
      chk("t4_addr", 65'(inst_addr), 65'(32'h1c004000));
      chk("t4_req", 65'(inst_req), 65'(1'b1));
      chk("t4_empty", 65'(fs2ds_valid), 65'(1'b0));
      repeat (3) tick();
      chk("t4_cnt", 65'(got.size()), 65'(13));
      chk("t4_e", got[12], ent(1'b0, 32'h1c004000, mem_word(32'h1c004000)));

      // T5: misaligned ertn target raises ADEF and halts
      ertn_flush = 1'b1;
      ertn_entry = 32'h1c000102;
      tick();
      ertn_flush = 1'b0;
      #1;
      chk("t5_req0", 65'(inst_req), 65'(1'b0));
      chk("t5_valid0", 65'(fs2ds_valid), 65'(1'b0));
      tick();
      chk("t5_valid1", 65'(fs2ds_valid), 65'(1'b1));
      chk("t5_adef", fs2ds_bus, ent(1'b1, 32'h1c000102, 32'h03400000));
      repeat (4) tick();
      chk("t5_req_halt", 65'(inst_req), 65'(1'b0));
      chk("t5_valid_halt", 65'(fs2ds_valid), 65'(1'b0));
      chk("t5_cnt", 65'(got.size()), 65'(14));
      chk("t5_reqs", 65'(req_log.size()), 65'(21));
      ws_ex    = 1'b1;
      ex_entry = 32'h1c008000;
      tick();
      ws_ex = 1'b0;
      #1;
      chk("t5_resume_req", 65'(inst_req), 65'(1'b1));
      chk("t5_resume_addr", 65'(inst_addr), 65'(32'h1c008000));
      repeat (3) tick();
      chk("t5_e", got[14], ent(1'b0, 32'h1c008000, mem_word(32'h1c008000)));

      // T6: reset mid-stream with three outstanding
      tick();
      resp_en    = 1'b0;
      ds_allowin = 1'b0;
      repeat (2) tick();
      chk("t6_pre_valid", 65'(fs2ds_valid), 65'(1'b1));
      chk("t6_reqs", 65'(req_log.size()), 65'(27));
      resetn = 1'b0;
      #1;
      chk("t6_rst_req", 65'(inst_req), 65'(1'b0));
      chk("t6_rst_valid", 65'(fs2ds_valid), 65'(1'b0));
      tick();
      resetn = 1'b1;
      pend.delete();
      pend.push_back(32'h1c00800c);
      resp_en    = 1'b1;
      ds_allowin = 1'b1;
      repeat (3) tick();
      chk("t6_restart_req", 65'(req_log[27]), 65'(32'h1c000000));
      chk("t6_cnt", 65'(got.size()), 65'(17));
      chk("t6_e", got[16], ent(1'b0, 32'h1c000000, mem_word(32'h1c000000)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
